// File: rtl/cam_pkg.sv
// ============================================================================
//  Module   : cam_pkg
//  Purpose  : Shared types and constants for the camera test-pattern source:
//             FSM state encoding, pattern mode encoding and the RGB444
//             colour-bar table.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_CHECK = 2'd3
  } mode_t;

  // Width used for pixel coordinates handed to the colour generator.
  localparam int COORD_W = 16;

  // Bar colours, bar 0 in the least significant 12 bits.
  localparam logic [8*12-1:0] BAR_TABLE = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
    return BAR_TABLE[idx*12 +: 12];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cam_pattern_pix.sv
// ============================================================================
//  Module   : cam_pattern_pix
//  Purpose  : Combinational RGB444 colour generator for one pixel position.
//  Ports    : x, y       - pixel coordinates (only y[3:0] affects any pattern)
//             mode       - pattern select (bars / gradient / solid / checker)
//             solid      - colour used in solid mode
//             frame_cnt  - frame parity, phases the checkerboard
//             rgb        - resulting 12-bit RGB444 colour
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_pattern_pix
  import cam_pkg::*;
#(
  parameter int IMG_W = 160
) (
  input  logic [COORD_W-1:0] x,
  input  logic [3:0]         y,
  input  mode_t              mode,
  input  logic [11:0]        solid,
  input  logic               frame_cnt,
  output logic [11:0]        rgb
);

  localparam int BAR_W = (IMG_W / 8 > 0) ? IMG_W / 8 : 1;

  logic [COORD_W-1:0] bar_idx;

  always_comb begin
    bar_idx = x / COORD_W'(BAR_W);
    rgb     = 12'h000;
    case (mode)
      // Clamp keeps the rightmost leftover columns on the last bar when
      // IMG_W is not a multiple of 8.
      MODE_BARS:  rgb = bar_rgb((bar_idx > COORD_W'(7)) ? 3'd7 : bar_idx[2:0]);
      MODE_GRAD:  rgb = {x[3:0], y[3:0], x[7:4]};
      MODE_SOLID: rgb = solid;
      MODE_CHECK: rgb = (x[3] ^ y[3] ^ frame_cnt) ? 12'hFFF : 12'h000;
      default:    rgb = 12'h000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cam_pattern_gen.sv
// ============================================================================
//  Module   : cam_pattern_gen
//  Purpose  : Camera-side test-pattern source producing vsync/href framing and
//             a two-bytes-per-pixel RGB444 stream (byte0 = {0,R}, byte1 = {G,B}).
//  Ports    : CAM_pclk    - pixel clock, rising edge
//             rst         - synchronous active-high reset
//             en          - run request, sampled only at frame start
//             mode        - pattern select, latched at VSYNC entry
//             solid_rgb   - solid colour, latched at VSYNC entry
//             CAM_vsync   - frame sync (registered)
//             CAM_href    - line valid (registered)
//             CAM_px_data - pixel byte, 0 while href is low (registered)
//             frame_done  - one-cycle pulse on the last frame cycle
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int HBLANK   = 16,
  parameter int VSYNC_LN = 3,
  parameter int VBP_LN   = 2,
  parameter int VFP_LN   = 2
) (
  input  logic        CAM_pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done
);

  localparam int LL     = 2 * IMG_W + HBLANK;
  localparam int CW_RAW = $clog2(LL);
  localparam int CW     = (CW_RAW < 2) ? 2 : CW_RAW;
  localparam int LN_A   = (IMG_H > VSYNC_LN) ? IMG_H : VSYNC_LN;
  localparam int LN_B   = (VBP_LN > VFP_LN) ? VBP_LN : VFP_LN;
  localparam int LN_MAX = (LN_A > LN_B) ? LN_A : LN_B;
  localparam int LW_RAW = $clog2(LN_MAX);
  localparam int LW     = (LW_RAW < 4) ? 4 : LW_RAW;

  state_t         state, state_n;
  logic [CW-1:0]  cyc, cyc_n;
  logic [LW-1:0]  line, line_n, last_line;
  logic           cyc_last;
  mode_t          mode_lat;
  logic [11:0]    solid_lat;
  logic           fcnt;

  logic           vs_d, hr_d, fd_d;
  logic [7:0]     px_d;
  logic [11:0]    rgb;

  // ---------------- state register (also holds counters and outputs) -------
  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cyc         <= '0;
      line        <= '0;
      mode_lat    <= MODE_BARS;
      solid_lat   <= 12'h000;
      fcnt        <= 1'b0;
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_px_data <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      cyc         <= cyc_n;
      line        <= line_n;
      CAM_vsync   <= vs_d;
      CAM_href    <= hr_d;
      CAM_px_data <= px_d;
      frame_done  <= fd_d;
      if (state_n == ST_VSYNC && state != ST_VSYNC) begin
        mode_lat  <= mode_t'(mode);
        solid_lat <= solid_rgb;
      end
      if (frame_done) fcnt <= ~fcnt;
    end
  end

  // ---------------- next-state logic ---------------------------------------
  always_comb begin
    last_line = '0;
    case (state)
      ST_VSYNC:  last_line = LW'(VSYNC_LN - 1);
      ST_VBP:    last_line = LW'(VBP_LN - 1);
      ST_ACTIVE: last_line = LW'(IMG_H - 1);
      ST_VFP:    last_line = LW'(VFP_LN - 1);
      default:   last_line = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    line_n   = line;
    cyc_last = (cyc == CW'(LL - 1));
    if (state == ST_IDLE) begin
      cyc_n  = '0;
      line_n = '0;
      if (en) state_n = ST_VSYNC;
    end else begin
      cyc_n = cyc_last ? '0 : cyc + 1'b1;
      if (cyc_last) begin
        if (line == last_line) begin
          line_n = '0;
          case (state)
            ST_VSYNC:  state_n = ST_VBP;
            ST_VBP:    state_n = ST_ACTIVE;
            ST_ACTIVE: state_n = ST_VFP;
            ST_VFP:    state_n = en ? ST_VSYNC : ST_IDLE;
            default:   state_n = ST_IDLE;
          endcase
        end else begin
          line_n = line + 1'b1;
        end
      end
    end
  end

  // ---------------- output logic -------------------------------------------
  // Outputs are decoded from the next-cycle position and then registered, so
  // the registered outputs line up with the state they describe.
  cam_pattern_pix #(
    .IMG_W (IMG_W)
  ) u_pix (
    .x         (COORD_W'(cyc_n[CW-1:1])),
    .y         (line_n[3:0]),
    .mode      (mode_lat),
    .solid     (solid_lat),
    .frame_cnt (fcnt),
    .rgb       (rgb)
  );

  always_comb begin
    vs_d = (state_n == ST_VSYNC);
    hr_d = (state_n == ST_ACTIVE) && (cyc_n < CW'(2 * IMG_W));
    px_d = 8'h00;
    if (hr_d) px_d = cyc_n[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
    fd_d = (state_n == ST_VFP) && (cyc_n == CW'(LL - 1)) &&
           (line_n == LW'(VFP_LN - 1));
  end

endmodule

`default_nettype wire

// File: tb/tb_cam_pattern_gen.sv
// ============================================================================
//  Module   : tb_cam_pattern_gen
//  Purpose  : Self-checking bench for cam_pattern_gen (reduced frame height).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_pattern_gen;

  localparam int IMG_W    = 160;
  localparam int IMG_H    = 8;
  localparam int HBLANK   = 16;
  localparam int VSYNC_LN = 3;
  localparam int VBP_LN   = 2;
  localparam int VFP_LN   = 2;
  localparam int LL       = 2 * IMG_W + HBLANK;
  localparam int ACT0     = VSYNC_LN + VBP_LN;
  localparam int FRAME    = (VSYNC_LN + VBP_LN + IMG_H + VFP_LN) * LL;

  logic        CAM_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic        CAM_vsync, CAM_href, frame_done;
  logic [7:0]  CAM_px_data;

  cam_pattern_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .HBLANK(HBLANK),
    .VSYNC_LN(VSYNC_LN), .VBP_LN(VBP_LN), .VFP_LN(VFP_LN)
  ) dut (
    .CAM_pclk    (CAM_pclk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .CAM_vsync   (CAM_vsync),
    .CAM_href    (CAM_href),
    .CAM_px_data (CAM_px_data),
    .frame_done  (frame_done)
  );

  always #5 CAM_pclk = ~CAM_pclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the running frame plus per-frame settings.
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [11:0] m_solid = 12'h000;
  bit          m_fc = 1'b0;

  int   vs_cnt = 0, rise_cnt = 0, fd_cnt = 0, gcyc = 0, last_rise = -1;
  logic prev_href = 1'b0;
  int   cap_y = -1;
  logic [7:0] cap [2*IMG_W];

  function automatic logic [11:0] color(input int x, input int y,
                                        input logic [1:0] md,
                                        input logic [11:0] sol, input bit fc);
    logic [3:0] r, g, b;
    case (md)
      2'd0: begin
        case (x / (IMG_W / 8))
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      2'd1: begin
        r = 4'(x % 16);
        g = 4'(y % 16);
        b = 4'((x / 16) % 16);
        return {r, g, b};
      end
      2'd2: return sol;
      default: return ((((x / 8) + (y / 8) + int'(fc)) % 2) == 1) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, m_t, got, exp);
    end
  endtask

  task automatic clear_stats();
    vs_cnt = 0; rise_cnt = 0; fd_cnt = 0; last_rise = -1;
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // clock the DUT, then compare every output.
  task automatic step();
    int L, c, y, x;
    logic e_vs, e_hr, e_fd;
    logic [7:0] e_px;
    logic [11:0] rgb;
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_fc = 1'b0;
    end else if (!m_run) begin
      if (en) begin m_run = 1'b1; m_t = 0; m_mode = mode; m_solid = solid_rgb; end
    end else if (m_t == FRAME - 1) begin
      m_fc = ~m_fc;
      if (en) begin m_t = 0; m_mode = mode; m_solid = solid_rgb; end
      else m_run = 1'b0;
    end else begin
      m_t++;
    end
    e_vs = 1'b0; e_hr = 1'b0; e_fd = 1'b0; e_px = 8'h00; y = -1; c = 0;
    if (m_run) begin
      L = m_t / LL;
      c = m_t % LL;
      e_vs = (L < VSYNC_LN);
      if (L >= ACT0 && L < ACT0 + IMG_H) begin
        y = L - ACT0;
        e_hr = (c < 2 * IMG_W);
        if (e_hr) begin
          x = c / 2;
          rgb = color(x, y, m_mode, m_solid, m_fc);
          e_px = (c % 2 == 0) ? {4'h0, rgb[11:8]} : rgb[7:0];
        end
      end
      e_fd = (m_t == FRAME - 1);
    end
    @(posedge CAM_pclk);
    #1;
    gcyc++;
    check("vsync", 32'(CAM_vsync), 32'(e_vs));
    check("href", 32'(CAM_href), 32'(e_hr));
    check("px_data", 32'(CAM_px_data), 32'(e_px));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    if (CAM_vsync) begin vs_cnt++; last_rise = -1; end
    if (CAM_href && !prev_href) begin
      rise_cnt++;
      if (last_rise >= 0) check("href_period", 32'(gcyc - last_rise), 32'(LL));
      last_rise = gcyc;
    end
    prev_href = CAM_href;
    if (frame_done) fd_cnt++;
    if (e_hr && y == cap_y) cap[c] = CAM_px_data;
  endtask

  initial begin
    // Reset and idle with en low.
    rst = 1'b1; en = 1'b0; mode = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();

    // Frame A: bars; mode changed mid-frame must not apply yet.
    en = 1'b1; mode = 2'd0; cap_y = 0; clear_stats();
    repeat (2000) step();
    mode = 2'd1;
    repeat (FRAME - 2000) step();
    check("A_vsync_len", 32'(vs_cnt), 32'(1008));
    check("A_href_pulses", 32'(rise_cnt), 32'(IMG_H));
    check("A_done", 32'(fd_cnt), 32'(1));
    check("A_px0_b0", 32'(cap[0]), 32'h0F);
    check("A_px0_b1", 32'(cap[1]), 32'hFF);
    check("A_px20_b0", 32'(cap[40]), 32'h0F);
    check("A_px20_b1", 32'(cap[41]), 32'hF0);
    check("A_px159_b0", 32'(cap[318]), 32'h00);
    check("A_px159_b1", 32'(cap[319]), 32'h00);

    // Frame B: gradient.
    cap_y = 5; clear_stats();
    repeat ($urandom_range(100, 3000)) step();
    mode = 2'd3;
    while (m_t != FRAME - 1) step();
    check("B_px37_b0", 32'(cap[74]), 32'h05);
    check("B_px37_b1", 32'(cap[75]), 32'h52);
    check("B_done", 32'(fd_cnt), 32'(1));

    // Frames C and D: checker with alternating phase.
    cap_y = 0; clear_stats();
    repeat (FRAME) step();
    check("C_px00_b0", 32'(cap[0]), 32'h00);
    check("C_px00_b1", 32'(cap[1]), 32'h00);
    check("C_done", 32'(fd_cnt), 32'(1));
    clear_stats();
    repeat (1000) step();
    mode = 2'd2; solid_rgb = 12'($urandom);
    repeat (FRAME - 1000) step();
    check("D_px00_b0", 32'(cap[0]), 32'h0F);
    check("D_px00_b1", 32'(cap[1]), 32'hFF);
    check("D_done", 32'(fd_cnt), 32'(1));

    // Frame E: solid, en dropped mid-ACTIVE; frame completes then idles.
    clear_stats();
    repeat (ACT0 * LL + $urandom_range(0, IMG_H * LL - 1)) step();
    en = 1'b0;
    solid_rgb = 12'($urandom);
    for (int i = 0; i < FRAME && m_run; i++) step();
    check("E_done", 32'(fd_cnt), 32'(1));
    repeat (50) step();
    check("E_idle_no_done", 32'(fd_cnt), 32'(1));

    // Two frames with random settings changing at random times.
    en = 1'b1; mode = 2'($urandom); solid_rgb = 12'($urandom); cap_y = -1;
    clear_stats();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ($urandom_range(0, 499) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 499) == 0) solid_rgb = 12'($urandom);
      step();
    end
    check("R_done", 32'(fd_cnt), 32'(2));

    // Reset during active line 5: abort, no frame_done, clean restart.
    for (int i = 0; i < FRAME && m_t != (ACT0 + 5) * LL + 77; i++) step();
    clear_stats();
    rst = 1'b1;
    repeat (2) step();
    check("rst_no_done", 32'(fd_cnt), 32'(0));
    rst = 1'b0; clear_stats();
    repeat (FRAME) step();
    check("rst_vsync_len", 32'(vs_cnt), 32'(1008));
    check("rst_done", 32'(fd_cnt), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
